// File: rtl/multiword_add_seq_if.sv
// multiword_add_seq_if: operand/result valid-ready bundle for the multiword add sequencer.
interface multiword_add_seq_if #(
    parameter int BW = 32,
    parameter int NW = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [NW*BW-1:0]  in_a;
    logic [NW*BW-1:0]  in_b;
    logic              in_cin;
    logic              out_valid;
    logic              out_ready;
    logic [NW*BW-1:0]  out_sum;
    logic              out_cout;
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: drives a registered BW-bit adder one word per cycle to build an NW*BW-bit sum.
module multiword_add_seq #(
    parameter int BW = 32,
    parameter int NW = 4
) (
    input  logic           CLK,
    input  logic           RESETn,
    multiword_add_seq_if.slave bus,
    output logic [BW-1:0]  add_a,
    output logic [BW-1:0]  add_b,
    output logic           add_cin,
    input  logic [BW-1:0]  add_sum,
    input  logic           add_cout
);
    localparam int W  = NW * BW;
    localparam int IW = $clog2(NW);
    localparam logic [IW-1:0] LAST = IW'(NW - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]             state;
    logic [IW-1:0]          idx;
    logic [W-1:0]           a_reg;
    logic [W-1:0]           b_reg;
    logic                   cin_reg;
    logic [(NW-1)*BW-1:0]   sum_reg;
    logic [W-1:0]           sum_out;
    logic                   cout_out;
    logic                   valid_out;

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = valid_out;
    assign bus.out_sum   = sum_out;
    assign bus.out_cout  = cout_out;
    // Word 0 takes the operand carry; later words chain the adder's registered carry.
    assign add_cin = (state == ISSUE) && (idx == '0 ? cin_reg : add_cout);

    // Operand registers shift down one word per issue so the next word is always at the bottom.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            cin_reg   <= 1'b0;
            sum_reg   <= '0;
            sum_out   <= '0;
            cout_out  <= 1'b0;
            valid_out <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_reg   <= bus.in_a >> BW;
                    b_reg   <= bus.in_b >> BW;
                    add_a   <= bus.in_a[BW-1:0];
                    add_b   <= bus.in_b[BW-1:0];
                    cin_reg <= bus.in_cin;
                    idx     <= '0;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    add_a <= a_reg[BW-1:0];
                    add_b <= b_reg[BW-1:0];
                    a_reg <= a_reg >> BW;
                    b_reg <= b_reg >> BW;
                    if (idx != '0) sum_reg[(int'(idx) - 1) * BW +: BW] <= add_sum;
                    idx   <= idx == LAST ? '0 : idx + 1'b1;
                    state <= idx == LAST ? DRAIN : ISSUE;
                end
                DRAIN: begin
                    sum_out   <= {add_sum, sum_reg};
                    cout_out  <= add_cout;
                    valid_out <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    valid_out <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: scoreboard bench with a registered adder model and an exact-arithmetic golden sum.
module tb_multiword_add_seq;
    localparam int BW = 32;
    localparam int NW = 4;
    localparam int W  = NW * BW;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    logic [BW-1:0] add_a, add_b, add_sum;
    logic add_cin, add_cout;
    int checks = 0;
    int errors = 0;
    bit hold = 1'b0;
    bit rand_rdy = 1'b0;
    logic [W:0] exp_q[$];

    multiword_add_seq_if #(.BW(BW), .NW(NW)) bus ();

    multiword_add_seq #(.BW(BW), .NW(NW)) dut (
        .CLK(CLK), .RESETn(RESETn), .bus(bus),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    always #5 CLK = ~CLK;

    // Environment adder: registers the word sum with one cycle of latency.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) {add_cout, add_sum} <= '0;
        else {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + (BW + 1)'(add_cin);
    end

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #2 bus.out_ready = !hold && (!rand_rdy || $urandom_range(0, 3) != 0);
        end
    end

    always @(negedge CLK) begin
        if (RESETn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", {bus.out_cout, bus.out_sum}, '1 ^ {bus.out_cout, bus.out_sum});
            else chk("result", {bus.out_cout, bus.out_sum}, exp_q.pop_front());
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input bit push);
        int n = 0;
        #1;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_cin = cin;
        bus.in_valid = 1'b1;
        @(negedge CLK);
        while (!bus.in_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        @(posedge CLK);
        if (push) exp_q.push_back({1'b0, a} + {1'b0, b} + (W + 1)'(cin));
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge CLK);
            #1 n++;
        end while (!bus.out_valid && n < 100);
        if (!bus.out_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge CLK);
            #1 n++;
        end
        if (!bus.in_ready) chk("idle_timeout", 0, 1);
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        for (int k = 0; k < NW; k++) v[k*BW +: BW] = $urandom;
        return v;
    endfunction

    initial begin
        int n;
        logic [W:0] s0;
        logic [W-1:0] a, b;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_cin = 1'b0;
        repeat (3) @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK);
        #1;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_sum", bus.out_sum, 0);
        chk("reset_out_cout", bus.out_cout, 0);
        chk("reset_add_bus", {add_a, add_b, add_cin}, 0);

        send(1, 2, 1'b0, 1'b1);
        chk("in_ready_after_accept", bus.in_ready, 0);
        wait_valid(n);
        chk("latency", n, NW + 1);
        chk("in_ready_while_valid", bus.in_ready, 0);
        @(posedge CLK);
        #1;
        chk("in_ready_after_handshake", bus.in_ready, 1);
        chk("valid_after_handshake", bus.out_valid, 0);

        send('1, 0, 1'b1, 1'b1);
        chk("ripple_cin_word0", add_cin, 1);
        for (int k = 1; k < NW; k++) begin
            @(posedge CLK);
            #1 chk($sformatf("ripple_cin_word%0d", k), add_cin, 1);
        end
        wait_idle();

        send(W'(64'hFFFF_FFFF), 1, 1'b0, 1'b1);
        wait_idle();

        hold = 1'b1;
        send(rnd(), rnd(), 1'b1, 1'b1);
        wait_valid(n);
        s0 = {bus.out_cout, bus.out_sum};
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = k[0];
            bus.in_a = rnd();
            @(posedge CLK);
            #1;
            chk("bp_valid_held", bus.out_valid, 1);
            chk("bp_sum_stable", {bus.out_cout, bus.out_sum}, s0);
            chk("bp_no_accept", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        hold = 1'b0;
        wait_idle();
        chk("bp_released_valid", bus.out_valid, 0);

        send(rnd(), rnd(), 1'b1, 1'b0);
        @(posedge CLK);
        #1 RESETn = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sum", {bus.out_cout, bus.out_sum}, 0);
        chk("rst_add_bus", {add_a, add_b, add_cin}, 0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK);
        #1 chk("rst_in_ready", bus.in_ready, 1);
        send(5, 7, 1'b0, 1'b1);
        wait_idle();

        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = rnd();
            b = rnd();
            case ($urandom_range(0, 7))
                0: a = '1;
                1: b = ~a;
                default: ;
            endcase
            send(a, b, 1'($urandom), 1'b1);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge CLK);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
